// File: rtl/temp_pwm_ctrl.sv
// Temperature-loop heater PWM controller: Avalon-MM register file, 8-channel PWM,
// watchdog that trips the heaters off if software stops refreshing the duty.
module temp_pwm_ctrl #(
  parameter int unsigned PRESCALE  = 195,
  parameter logic [15:0] WDOG_INIT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_port,
  output logic        irq
);

  localparam int unsigned PRE_W = 16;
  localparam int unsigned CH_W  = 8;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRIP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              enable_q, enable_d;
  logic [CH_W-1:0]   duty_q, duty_d;
  logic [CH_W-1:0]   mask_q, mask_d;
  logic [15:0]       wdog_q, wdog_d;
  logic [CH_W-1:0]   duty_act_q, duty_act_d;
  logic [CH_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [15:0]       wdog_cnt_q, wdog_cnt_d;
  logic [CH_W-1:0]   out_port_q, out_port_d;
  logic              irq_q, irq_d;

  logic wr_en, ctrl_wr, duty_wr, mask_wr, wdog_wr, tick;
  logic unused_wdata;

  assign wr_en   = chipselect & ~write_n;
  assign ctrl_wr = wr_en && (address == 3'd0);
  assign duty_wr = wr_en && (address == 3'd1);
  assign mask_wr = wr_en && (address == 3'd2);
  assign wdog_wr = wr_en && (address == 3'd3);
  assign tick    = (presc_q == PRE_LAST);
  assign unused_wdata = ^writedata[31:16];

  // Next-state: prescaler/PWM timebase, register writes, control FSM, outputs
  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    duty_d     = duty_q;
    mask_d     = mask_q;
    wdog_d     = wdog_q;
    duty_act_d = duty_act_q;
    pwm_cnt_d  = pwm_cnt_q;
    presc_d    = tick ? '0 : presc_q + PRE_W'(1);
    wdog_cnt_d = wdog_cnt_q;

    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + CH_W'(1);
      if (pwm_cnt_q == 8'hFF) duty_act_d = duty_q;
    end

    // clear_trip in the same write always leaves enable low
    if (ctrl_wr) enable_d = writedata[0] & ~writedata[1];
    if (duty_wr) duty_d = writedata[7:0];
    if (mask_wr) mask_d = writedata[7:0];
    if (wdog_wr) wdog_d = writedata[15:0];

    case (state_q)
      ST_IDLE: begin
        if (enable_q) begin
          state_d    = ST_RUN;
          wdog_cnt_d = wdog_q;
          pwm_cnt_d  = '0;
          presc_d    = '0;
          duty_act_d = duty_q;
        end
      end
      ST_RUN: begin
        // A refresh in the expiry cycle beats the trip
        if (ctrl_wr && !enable_d) begin
          state_d = ST_IDLE;
        end else if (duty_wr) begin
          wdog_cnt_d = wdog_q;
        end else if (wdog_cnt_q == 16'd0) begin
          state_d  = ST_TRIP;
          enable_d = 1'b0;
        end else if (tick) begin
          wdog_cnt_d = wdog_cnt_q - 16'd1;
        end
      end
      ST_TRIP: begin
        enable_d = 1'b0;
        if (ctrl_wr && writedata[1]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    out_port_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && (pwm_cnt_q < duty_act_q))
      out_port_d = mask_q;
    irq_d = (state_d == ST_TRIP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      enable_q   <= 1'b0;
      duty_q     <= '0;
      mask_q     <= '0;
      wdog_q     <= WDOG_INIT;
      duty_act_q <= '0;
      pwm_cnt_q  <= '0;
      presc_q    <= '0;
      wdog_cnt_q <= '0;
      out_port_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      duty_q     <= duty_d;
      mask_q     <= mask_d;
      wdog_q     <= wdog_d;
      duty_act_q <= duty_act_d;
      pwm_cnt_q  <= pwm_cnt_d;
      presc_q    <= presc_d;
      wdog_cnt_q <= wdog_cnt_d;
      out_port_q <= out_port_d;
      irq_q      <= irq_d;
    end
  end

  // Read mux; side-effect free
  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = {31'd0, enable_q};
      3'd1:    readdata = {24'd0, duty_q};
      3'd2:    readdata = {24'd0, mask_q};
      3'd3:    readdata = {16'd0, wdog_q};
      3'd4:    readdata = {wdog_cnt_q, duty_act_q, 6'd0, state_q};
      default: readdata = '0;
    endcase
  end

  assign out_port = out_port_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_temp_pwm_ctrl.sv
// Bench for temp_pwm_ctrl: spec-level cycle model compared every cycle, plus
// hand-computed PWM widths, trip latencies and reset values.
module tb_temp_pwm_ctrl;

  localparam int PRE = 2;
  localparam logic [15:0] WINIT = 16'd1000;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        irq;

  temp_pwm_ctrl #(.PRESCALE(PRE), .WDOG_INIT(WINIT)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: 0 idle, 1 run, 2 trip; plain integers throughout
  typedef struct {
    int st; int en; int duty; int mask; int wdog;
    int da; int pwm; int pre; int wc; int outv; int irqv;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 0; r.en = 0; r.duty = 0; r.mask = 0; r.wdog = int'(WINIT);
    r.da = 0; r.pwm = 0; r.pre = 0; r.wc = 0; r.outv = 0; r.irqv = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t c, bit wr, int a, logic [31:0] d);
    mdl_t n;
    bit tk;
    n = c;
    tk = (c.pre == PRE - 1);
    n.pre = tk ? 0 : c.pre + 1;
    if (tk) begin
      n.pwm = (c.pwm + 1) % 256;
      if (c.pwm == 255) n.da = c.duty;
    end
    if (wr) begin
      if (a == 0) n.en = (d[0] && !d[1]) ? 1 : 0;
      if (a == 1) n.duty = int'(d[7:0]);
      if (a == 2) n.mask = int'(d[7:0]);
      if (a == 3) n.wdog = int'(d[15:0]);
    end
    if (c.st == 0) begin
      if (c.en == 1) begin
        n.st = 1; n.wc = c.wdog; n.pwm = 0; n.pre = 0; n.da = c.duty;
      end
    end else if (c.st == 1) begin
      if (wr && a == 0 && n.en == 0) n.st = 0;
      else if (wr && a == 1) n.wc = c.wdog;
      else if (c.wc == 0) begin n.st = 2; n.en = 0; end
      else if (tk) n.wc = c.wc - 1;
    end else begin
      n.en = 0;
      if (wr && a == 0 && d[1]) n.st = 0;
    end
    n.outv = (c.st == 1 && n.st == 1 && c.pwm < c.da) ? c.mask : 0;
    n.irqv = (n.st == 2) ? 1 : 0;
    return n;
  endfunction

  function automatic logic [31:0] mread(mdl_t c, logic [2:0] a);
    case (a)
      3'd0: return 32'(c.en);
      3'd1: return 32'(c.duty);
      3'd2: return 32'(c.mask);
      3'd3: return 32'(c.wdog);
      3'd4: return {16'(c.wc), 8'(c.da), 6'd0, 2'(c.st)};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= mreset();
    else m <= step(m, chipselect && !write_n, int'(address), writedata);
  end

  // Every-cycle comparison against the model
  always begin
    @(posedge clk);
    #2;
    chk("cyc_out_port", 32'(out_port), 32'(m.outv));
    chk("cyc_irq", 32'(irq), 32'(m.irqv));
    chk("cyc_readdata", readdata, mread(m, address));
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = 3'd4; writedata = 32'd0;
  endtask

  task automatic rdchk(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
    address = 3'd4;
  endtask

  task automatic wait_lvl(input logic lvl);
    int g;
    g = 0;
    while (out_port[0] !== lvl && g < 3000) begin @(negedge clk); g++; end
    chk("wait_level_timeout", 32'(g >= 3000), 32'd0);
  endtask

  task automatic meas(input logic lvl, output int len);
    len = 0;
    while (out_port[0] === lvl && len < 4000) begin @(negedge clk); len++; end
  endtask

  task automatic wait_irq(output int k);
    k = 0;
    while (!irq && k < 200) begin @(negedge clk); k++; end
  endtask

  int len, k, h;

  initial begin
    address = 3'd4; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rdchk("rst_wdog", 3'd3, 32'd1000);
    rdchk("rst_status", 3'd4, 32'd0);
    @(negedge clk) reset_n = 1'b1;

    // Unmapped addresses
    wr(3'd5, 32'hFFFF_FFFF);
    rdchk("addr5_read", 3'd5, 32'd0);
    rdchk("mask_untouched", 3'd2, 32'd0);

    // Duty 64, prescale 2: 128 clk high, 384 low
    wr(3'd2, 32'd1);
    wr(3'd1, 32'd64);
    wr(3'd0, 32'd1);
    wait_lvl(1'b1);
    meas(1'b1, len); chk("d64_high", 32'(len), 32'd128);
    meas(1'b0, len); chk("d64_low", 32'(len), 32'd384);
    meas(1'b1, len); chk("d64_high2", 32'(len), 32'd128);
    // Mid-period duty change takes effect only at the wrap
    wr(3'd1, 32'd200);
    meas(1'b0, len); chk("d200_hold_low", 32'(len), 32'd382);
    chk("other_bits", 32'(out_port[7:1]), 32'd0);
    meas(1'b1, len); chk("d200_high", 32'(len), 32'd400);
    meas(1'b0, len); chk("d200_low", 32'(len), 32'd112);

    // WDOG=0 trips on the cycle after entering RUN
    wr(3'd0, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd1);
    wait_irq(k); chk("wdog0_trip_lat", 32'(k), 32'd2);
    wr(3'd0, 32'd3);

    // WDOG=10, no refresh: trip 22 clocks after the enable write
    wr(3'd3, 32'd10);
    wr(3'd0, 32'd1);
    wait_irq(k); chk("wdog10_trip_lat", 32'(k), 32'd22);
    #1;
    chk("trip_out", 32'(out_port), 32'd0);
    rdchk("trip_status", 3'd4, 32'h0000_C802);
    rdchk("trip_ctrl", 3'd0, 32'd0);

    // Clear trip with enable also set: back to IDLE, enable stays 0
    wr(3'd0, 32'd3);
    #1;
    chk("clr_irq", 32'(irq), 32'd0);
    rdchk("clr_status", 3'd4, 32'h0000_C800);
    rdchk("clr_ctrl", 3'd0, 32'd0);

    // Re-enable, then refresh exactly on the tick that would reach 0
    wr(3'd0, 32'd1);
    repeat (19) @(negedge clk);
    wr(3'd1, 32'd100);
    rdchk("refresh_at_expiry", 3'd4, 32'h000A_C801);
    repeat (3) @(negedge clk);
    chk("no_trip_after_refresh", 32'(irq), 32'd0);

    // Duty 0: constant low
    wr(3'd3, 32'd1000);
    wr(3'd1, 32'd0);
    repeat (600) @(negedge clk);
    h = 0;
    repeat (520) begin @(negedge clk); if (out_port[0]) h++; end
    chk("duty0_high", 32'(h), 32'd0);

    // Duty 255: 510 clk high, 2 low
    wr(3'd1, 32'd255);
    wait_lvl(1'b1);
    meas(1'b1, len); chk("d255_high", 32'(len), 32'd510);
    meas(1'b0, len); chk("d255_low", 32'(len), 32'd2);

    // Asynchronous reset mid-period
    repeat (10) @(negedge clk);
    chk("pre_reset_out", 32'(out_port[0]), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out_port), 32'd0);
    chk("async_rst_irq", 32'(irq), 32'd0);
    rdchk("async_rst_ctrl", 3'd0, 32'd0);
    rdchk("async_rst_duty", 3'd1, 32'd0);
    rdchk("async_rst_mask", 3'd2, 32'd0);
    rdchk("async_rst_wdog", 3'd3, 32'd1000);
    rdchk("async_rst_status", 3'd4, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (5) @(negedge clk);
    rdchk("post_rst_status", 3'd4, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_pwm_ctrl.md
TEMP_PWM_CTRL -- requirements
Module: temp_pwm_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 195, clk cycles per PWM tick, legal range 1..65535.
REQ-002 SHALL have parameter WDOG_INIT, default 16'd1000, watchdog reload value at reset, in PWM ticks.
REQ-003 Port: clk  in  1  single clock; all logic rising-edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: address  in  3  Avalon-MM word address.
REQ-006 Port: chipselect  in  1  Avalon-MM select.
REQ-007 Port: write_n  in  1  active-low write strobe.
REQ-008 Port: writedata  in  32  write data.
REQ-009 Port: readdata  out  32  combinational read data; unused bits 0.
REQ-010 Port: out_port  out  8  heater PWM drive, one bit per channel.
REQ-011 Port: irq  out  1  level interrupt, high while state is TRIP.

Function
REQ-012 Write occurs when chipselect=1 and write_n=0; reads have no side effects.
REQ-013 Register map: 0 CTRL, 1 DUTY, 2 MASK, 3 WDOG, 4 STATUS. Addresses 5..7 read 0 and ignore writes.
REQ-014 CTRL: bit0 enable (R/W); bit1 clear_trip (write-1 pulse, reads 0).
REQ-015 DUTY: bits[7:0] duty_shadow (R/W).
REQ-016 MASK: bits[7:0] channel enable (R/W).
REQ-017 WDOG: bits[15:0] reload value (R/W).
REQ-018 STATUS (read-only): bits[1:0] state (IDLE=0, RUN=1, TRIP=2); bits[15:8] duty_active; bits[31:16] watchdog count.
REQ-019 Prescaler counts 0..PRESCALE-1 and then wraps. tick=1 for one cycle at count PRESCALE-1. It runs in all states.
REQ-020 pwm_cnt is 8-bit, increments on tick, wraps 255->0.
REQ-021 duty_active loads duty_shadow on the tick where pwm_cnt wraps 255->0, and also on the IDLE->RUN transition; it never changes mid-period otherwise.
REQ-022 out_port[i] = MASK[i] & (state==RUN) & (pwm_cnt < duty_active), registered, so it is 1 cycle after the terms.
REQ-023 duty 0 gives a constant-low channel; duty 255 is high for 255 of 256 ticks.
REQ-024 FSM IDLE->RUN: the cycle after enable=1 is observed in IDLE. On entry, watchdog count loads WDOG and pwm_cnt and the prescaler clear to 0.
REQ-025 FSM RUN->IDLE: on a CTRL write with enable=0; out_port is 0 from the next cycle.
REQ-026 In RUN, watchdog count decrements by 1 per tick, saturating at 0.
REQ-027 In RUN, a write to DUTY reloads watchdog count from WDOG.
REQ-028 FSM RUN->TRIP: when watchdog count is 0 in RUN. Entering TRIP clears enable and forces out_port to 0 on the next cycle.
REQ-029 Simultaneous DUTY write and the expiry tick: the reload wins and no TRIP occurs.
REQ-030 FSM TRIP->IDLE: only on a CTRL write with clear_trip=1.
REQ-031 In the clear_trip write cycle, the enable bit of that write is ignored and enable stays 0. RUN requires a separate later write.
REQ-032 A write to WDOG in RUN does not reload the count; the new value takes effect at the next reload.
REQ-033 WDOG=0 while entering RUN gives TRIP on the following cycle.

Reset
REQ-034 Asynchronous assertion of reset_n=0 SHALL immediately set: state IDLE, out_port 0, irq 0, CTRL 0, DUTY 0, MASK 0, WDOG=WDOG_INIT, duty_active 0, pwm_cnt 0, prescaler 0, watchdog count 0.
REQ-035 Reset mid-PWM-period or in TRIP SHALL take the same reset values; TRIP is not retained.
REQ-036 Release of reset SHALL be honoured on the first rising edge after deassertion.

Verification
REQ-037 PRESCALE=2, MASK=0x01, DUTY=64, enable=1 -> out_port[0] high 64 ticks (128 clk), low 192 ticks, repeating; other bits 0.
REQ-038 In RUN with DUTY=64, write DUTY=200 mid-period -> out_port unchanged until pwm_cnt wraps; the next period is high for 200 ticks.
REQ-039 WDOG=10, enable, no DUTY writes -> TRIP after 10 ticks; out_port=0, irq=1, STATUS[1:0]=2, CTRL.enable=0.
REQ-040 In TRIP, write CTRL=0x3 -> state IDLE, irq=0, outputs stay 0; a following CTRL=0x1 -> RUN.
REQ-041 A DUTY write in the exact cycle the watchdog reaches 0 -> no TRIP and count=WDOG; DUTY=0 and DUTY=255 boundary widths are checked.
REQ-042 reset_n low mid-period in RUN -> out_port 0 in the same cycle; all registers return to their REQ-034 values.
